// File: rtl/node_port_reader_if.sv
// Handshake bundle between the node datapath, the four neighbour links and the port reader.
// The reader uses the slave modport. The datapath/neighbour side (or a testbench) uses the master modport.
interface node_port_reader_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    logic             rd_req;
    logic [2:0]       rd_src;
    logic [DW-1:0]    nb_data0;
    logic [DW-1:0]    nb_data1;
    logic [DW-1:0]    nb_data2;
    logic [DW-1:0]    nb_data3;
    logic [3:0]       nb_valid;
    logic [3:0]       nb_ack;
    logic [DW-1:0]    rd_data;
    logic             rd_done;
    logic             stall;
    logic [1:0]       last_port;
    logic             last_vld;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output rd_req, rd_src, nb_data0, nb_data1, nb_data2, nb_data3, nb_valid,
        input  nb_ack, rd_data, rd_done, stall, last_port, last_vld, wait_cnt
    );

    modport slave (
        input  rd_req, rd_src, nb_data0, nb_data1, nb_data2, nb_data3, nb_valid,
        output nb_ack, rd_data, rd_done, stall, last_port, last_vld, wait_cnt
    );
endinterface

// File: rtl/node_port_reader.sv
// Consuming end of the inter-node port links: blocks on a chosen neighbour, acks one word, returns it.
//   state  | meaning
//   IDLE   | no read in flight, waiting for rd_req
//   WAIT   | source latched, stalling until the selected neighbour has a word
//   DONE   | rd_done and nb_ack pulse visible for this single cycle
module node_port_reader #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    node_port_reader_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0]       SRC_ANY  = 3'd4;
    localparam logic [2:0]       SRC_LAST = 3'd5;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       src_q, src_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;
    logic [3:0]       nb_ack_q, nb_ack_d;
    logic             rd_done_q, rd_done_d;
    logic             stall_q, stall_d;
    logic [1:0]       last_port_q, last_port_d;
    logic             last_vld_q, last_vld_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic             hit;
    logic             has_port;
    logic [1:0]       port;
    logic [DW-1:0]    sel_data;

    // Hit resolution; has_port=0 marks a NIL-style read that completes without consuming anything.
    always_comb begin
        hit      = 1'b0;
        has_port = 1'b0;
        port     = 2'd0;
        case (src_q)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                port     = src_q[1:0];
                has_port = 1'b1;
                hit      = bus.nb_valid[src_q[1:0]];
            end
            SRC_ANY: begin
                if (bus.nb_valid[3])      port = 2'd3;
                else if (bus.nb_valid[1]) port = 2'd1;
                else if (bus.nb_valid[0]) port = 2'd0;
                else                      port = 2'd2;
                hit      = |bus.nb_valid;
                has_port = |bus.nb_valid;
            end
            SRC_LAST: begin
                if (last_vld_q) begin
                    port     = last_port_q;
                    has_port = 1'b1;
                    hit      = bus.nb_valid[last_port_q];
                end else begin
                    hit = 1'b1;
                end
            end
            default: hit = 1'b1;
        endcase
    end

    always_comb begin
        sel_data = '0;
        case (port)
            2'd0:    sel_data = bus.nb_data0;
            2'd1:    sel_data = bus.nb_data1;
            2'd2:    sel_data = bus.nb_data2;
            default: sel_data = bus.nb_data3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        rd_data_d   = rd_data_q;
        nb_ack_d    = 4'b0000;
        rd_done_d   = 1'b0;
        stall_d     = 1'b0;
        last_port_d = last_port_q;
        last_vld_d  = last_vld_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rd_req) begin
                    src_d      = bus.rd_src;
                    wait_cnt_d = '0;
                    stall_d    = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (hit) begin
                    rd_data_d = has_port ? sel_data : '0;
                    if (has_port) nb_ack_d = 4'b0001 << port;
                    rd_done_d = 1'b1;
                    state_d   = S_DONE;
                    if (src_q == SRC_ANY) begin
                        last_port_d = port;
                        last_vld_d  = 1'b1;
                    end
                end else begin
                    stall_d = 1'b1;
                    if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            src_q       <= 3'd0;
            rd_data_q   <= '0;
            nb_ack_q    <= 4'b0000;
            rd_done_q   <= 1'b0;
            stall_q     <= 1'b0;
            last_port_q <= 2'd0;
            last_vld_q  <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            rd_data_q   <= rd_data_d;
            nb_ack_q    <= nb_ack_d;
            rd_done_q   <= rd_done_d;
            stall_q     <= stall_d;
            last_port_q <= last_port_d;
            last_vld_q  <= last_vld_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.nb_ack    = nb_ack_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.stall     = stall_q;
    assign bus.last_port = last_port_q;
    assign bus.last_vld  = last_vld_q;
    assign bus.wait_cnt  = wait_cnt_q;

endmodule
